pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Purpose: shared state encoding for the PLL lock sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_PDOWN  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer bringing an asynchronous level into clk_in.
// Latency: 2 clk_in edges from input change to q.
// Backpressure: none; free-running level path.
module sync_2ff (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Purpose: sequences PLL reset/power-down, waits for a stable lock, then releases downstream reset.
// Latency: pll_locked seen by the FSM 2 edges late; ready rises 2+STABLE_CYCLES edges after lock is sampled.
// Backpressure: none; control inputs are levels/pulses, outputs are Moore decodes of the state register.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 10000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         pll_locked,
  input  logic         pwrdwn_req,
  input  logic         relock_req,
  output logic         pll_rst,
  output logic         pll_pwrdwn,
  output logic         rst_out,
  output logic         ready,
  output logic         fault,
  output logic [2:0]   state,
  output logic [7:0]   lost_lock_count
);

  localparam int RST_W   = $clog2(RST_CYCLES) + 1;
  localparam int WAIT_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STAB_W  = $clog2(STABLE_CYCLES) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES) + 1;

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  state_t               state_q;
  state_t               state_nxt;
  logic                 locked_s;
  logic                 go;          // a transition is taken this cycle; per-state timers restart
  logic                 retry_inc;
  logic                 retry_clr;
  logic                 lost_evt;
  logic [RST_W-1:0]     rst_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [STAB_W-1:0]    stab_cnt;
  logic [RETRY_W-1:0]   retry_cnt;

  sync_2ff u_lock_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (pll_locked),
    .q      (locked_s)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_nxt;
  end

  // Next-state selection (pwrdwn > relock > lock/timer) and Moore output decode.
  always_comb begin
    state_nxt  = state_q;
    go         = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    lost_evt   = 1'b0;
    pll_rst    = 1'b0;
    pll_pwrdwn = 1'b0;
    rst_out    = 1'b1;
    ready      = 1'b0;
    fault      = 1'b0;

    if (state_q != S_PDOWN && pwrdwn_req) begin
      state_nxt = S_PDOWN;
      go        = 1'b1;
    end else if (state_q != S_PDOWN && relock_req) begin
      state_nxt = S_RESET;
      go        = 1'b1;
      retry_clr = 1'b1;
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state_nxt = S_WAIT;
            go        = 1'b1;
          end
        end
        S_WAIT: begin
          if (locked_s) begin
            state_nxt = S_STABLE;
            go        = 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            retry_inc = 1'b1;
            go        = 1'b1;
            state_nxt = ((retry_cnt + 1'b1) == RETRY_MAX) ? S_FAULT : S_RESET;
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_nxt = S_WAIT;
            go        = 1'b1;
          end else if (stab_cnt == STAB_LAST) begin
            state_nxt = S_RUN;
            go        = 1'b1;
            retry_clr = 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nxt = S_RESET;
            go        = 1'b1;
            lost_evt  = 1'b1;
          end
        end
        S_PDOWN: begin
          // Power-down restarts the attempt budget from scratch.
          retry_clr = 1'b1;
          if (!pwrdwn_req) begin
            state_nxt = S_RESET;
            go        = 1'b1;
          end
        end
        S_FAULT: begin
          state_nxt = S_FAULT;
        end
        default: begin
          state_nxt = S_RESET;
          go        = 1'b1;
        end
      endcase
    end

    case (state_q)
      S_RESET:  pll_rst = 1'b1;
      S_WAIT:   pll_rst = 1'b0;
      S_STABLE: pll_rst = 1'b0;
      S_RUN: begin
        rst_out = 1'b0;
        ready   = 1'b1;
      end
      S_PDOWN: begin
        pll_pwrdwn = 1'b1;
        pll_rst    = 1'b1;
      end
      S_FAULT: begin
        pll_rst = 1'b1;
        fault   = 1'b1;
      end
      default: pll_rst = 1'b1;
    endcase
  end

  // Per-state timers restart on every transition; retry and loss counters saturate.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rst_cnt         <= '0;
      wait_cnt        <= '0;
      stab_cnt        <= '0;
      retry_cnt       <= '0;
      lost_lock_count <= '0;
    end else begin
      rst_cnt  <= (state_q == S_RESET  && !go) ? rst_cnt  + 1'b1 : '0;
      wait_cnt <= (state_q == S_WAIT   && !go) ? wait_cnt + 1'b1 : '0;
      stab_cnt <= (state_q == S_STABLE && !go) ? stab_cnt + 1'b1 : '0;
      if (retry_clr)
        retry_cnt <= '0;
      else if (retry_inc && retry_cnt != RETRY_MAX)
        retry_cnt <= retry_cnt + 1'b1;
      if (lost_evt && lost_lock_count != 8'hFF)
        lost_lock_count <= lost_lock_count + 8'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose: directed self-checking bench for pll_lock_sequencer with short timing parameters.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clk_in edge.
// Backpressure: n/a.
module tb_pll_lock_sequencer;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pwrdwn_req;
  logic       relock_req;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       rst_out;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] lost_lock_count;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk_in          (clk_in),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .pwrdwn_req      (pwrdwn_req),
    .relock_req      (relock_req),
    .pll_rst         (pll_rst),
    .pll_pwrdwn      (pll_pwrdwn),
    .rst_out         (rst_out),
    .ready           (ready),
    .fault           (fault),
    .state           (state),
    .lost_lock_count (lost_lock_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int maxc, output bit ok);
    int n = 0;
    while (state !== exp && n < maxc) begin
      tick();
      n++;
    end
    ok = (state === exp);
  endtask

  task automatic count_state(input logic [2:0] st, output int n);
    n = 0;
    while (state === st && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic lose_and_relock(output bit ok);
    bit a;
    bit b;
    pll_locked = 1'b0;
    wait_state(3'd0, 10, a);
    pll_locked = 1'b1;
    wait_state(3'd3, 40, b);
    ok = a && b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},  state, 0);
    chk({tag, "_pllrst"}, pll_rst, 1);
    chk({tag, "_pwrdwn"}, pll_pwrdwn, 0);
    chk({tag, "_rstout"}, rst_out, 1);
    chk({tag, "_ready"},  ready, 0);
    chk({tag, "_fault"},  fault, 0);
    chk({tag, "_lost"},   lost_lock_count, 0);
  endtask

  initial begin
    int n;
    bit ok;
    int bad;

    rst        = 1'b1;
    pll_locked = 1'b0;
    pwrdwn_req = 1'b0;
    relock_req = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");

    // Bring-up: pll_rst pulse width, then lock 10 cycles after pll_rst falls.
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("bringup_rst_pulse", n, 4);
    chk("bringup_wait", state, 1);
    chk("bringup_rstout_wait", rst_out, 1);
    repeat (10) tick();
    pll_locked = 1'b1;
    tick();                       // first edge sampling pll_locked high
    repeat (9) tick();
    chk("bringup_ready_early", ready, 0);
    chk("bringup_stable", state, 2);
    tick();
    chk("bringup_ready", ready, 1);
    chk("bringup_rstout", rst_out, 0);
    chk("bringup_run", state, 3);

    // Loss of lock in RUN.
    pll_locked = 1'b0;
    tick();
    tick();
    chk("loss_still_run", state, 3);
    tick();
    chk("loss_reset", state, 0);
    chk("loss_rstout", rst_out, 1);
    chk("loss_count1", lost_lock_count, 1);
    pll_locked = 1'b1;
    wait_state(3'd3, 40, ok);
    chk("loss_relock_run", ok, 1);

    // Two more losses, then reset pulse while in RUN.
    lose_and_relock(ok);
    chk("loss2_ok", ok, 1);
    lose_and_relock(ok);
    chk("loss3_ok", ok, 1);
    chk("loss_count3", lost_lock_count, 3);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    wait_state(3'd3, 60, ok);
    chk("midrst_relock_run", ok, 1);

    // Saturation of the lost-lock counter.
    bad = 0;
    for (int i = 0; i < 254; i++) begin
      lose_and_relock(ok);
      if (!ok) bad++;
    end
    chk("sat_loop_timeouts", bad, 0);
    chk("sat_count254", lost_lock_count, 254);
    lose_and_relock(ok);
    chk("sat_count255", lost_lock_count, 255);
    lose_and_relock(ok);
    chk("sat_hold255", lost_lock_count, 255);

    // Glitch in STABLE: one low cycle after 5 cycles in STABLE.
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("relock_to_reset", state, 0);
    wait_state(3'd1, 20, ok);
    chk("glitch_wait_entry", ok, 1);
    pll_locked = 1'b1;
    wait_state(3'd2, 10, ok);
    chk("glitch_stable_entry", ok, 1);
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("glitch_hold_stable", state, 2);
    tick();
    chk("glitch_back_wait", state, 1);
    chk("glitch_ready_low", ready, 0);
    repeat (8) tick();
    chk("glitch_full_count", state, 2);
    tick();
    chk("glitch_run", state, 3);
    chk("glitch_ready", ready, 1);
    chk("glitch_no_loss", lost_lock_count, 255);

    // Precedence: pwrdwn_req beats relock_req in WAIT; relock ignored in PDOWN.
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    wait_state(3'd1, 20, ok);
    chk("prec_wait_entry", ok, 1);
    pwrdwn_req = 1'b1;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("prec_pdown", state, 4);
    chk("prec_pwrdwn", pll_pwrdwn, 1);
    chk("prec_pllrst", pll_rst, 1);
    chk("prec_rstout", rst_out, 1);
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("pdown_ignores_relock", state, 4);
    pwrdwn_req = 1'b0;
    tick();
    chk("pdown_exit", state, 0);
    chk("pdown_exit_pwrdwn", pll_pwrdwn, 0);

    // No lock: two reset pulses separated by full timeouts, then FAULT.
    count_state(3'd0, n);
    chk("nolock_pulse1", n, 4);
    count_state(3'd1, n);
    chk("nolock_gap1", n, 20);
    count_state(3'd0, n);
    chk("nolock_pulse2", n, 4);
    count_state(3'd1, n);
    chk("nolock_gap2", n, 20);
    chk("nolock_fault_state", state, 5);
    chk("nolock_fault", fault, 1);
    chk("nolock_pllrst", pll_rst, 1);
    chk("nolock_rstout", rst_out, 1);
    repeat (10) tick();
    chk("fault_sticky", state, 5);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("fault_relock_state", state, 0);
    chk("fault_relock_clear", fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
